// File: rtl/data_ram_pkg.sv
// Shared definitions for the byte-addressed data RAM: access-size encodings,
// FSM states and small constant helpers.
package data_ram_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  // Number of bytes touched by an access; 0 marks the reserved encoding.
  function automatic int access_bytes(input logic [1:0] sz, input int n);
    case (sz)
      SIZE_B:  return 1;
      SIZE_H:  return 2;
      SIZE_W:  return n / 8;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/data_ram_if.sv
// Request/response handshake bundle between a load/store client and data_ram.
interface data_ram_if #(
  parameter int N  = 32,
  parameter int AW = 10
);
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [AW-1:0] req_addr;
  logic [N-1:0]  req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [N-1:0]  rsp_rdata;
  logic          rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_ram_extend.sv
// Combinational load formatter: picks the low 1/2/N/8 bytes of a little-endian
// fetch and sign- or zero-extends them to N bits.
module data_ram_extend
  import data_ram_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N/8-1:0][7:0] raw,
  input  logic [1:0]          sz,
  input  logic                uns,
  output logic [N-1:0]        data
);

  logic [15:0] half;

  assign half = {raw[1], raw[0]};

  always_comb begin
    data = raw;
    case (sz)
      SIZE_B:  data = uns ? N'(raw[0]) : N'($signed(raw[0]));
      SIZE_H:  data = uns ? N'(half)   : N'($signed(half));
      default: ;
    endcase
  end

endmodule

// File: rtl/data_ram.sv
// Single-port byte-array RAM with a valid/ready request and a one-deep
// registered response; bad accesses are flagged and never touch memory.
module data_ram
  import data_ram_pkg::*;
#(
  parameter int N    = 32,
  parameter int SIZE = 1024
) (
  input  logic   clk,
  input  logic   rst,
  data_ram_if.slave bus
);

  localparam int AW = clog2(SIZE);
  localparam int NB = N / 8;

  logic [7:0] mem [SIZE];

  state_e              state_q, state_d;
  logic                accept;
  logic                acc_err;
  int                  nbytes;
  logic [AW:0]         end_addr;
  logic [NB-1:0][7:0]  raw;
  logic [N-1:0]        ext_data;
  logic [N-1:0]        rdata_q;
  logic                err_q;

  assign nbytes   = access_bytes(bus.req_size, N);
  assign end_addr = {1'b0, bus.req_addr} + (AW+1)'(nbytes);

  // nbytes is a power of two, so alignment is a mask test.
  always_comb begin
    acc_err = 1'b0;
    if (nbytes == 0)
      acc_err = 1'b1;
    else if ((bus.req_addr & AW'(nbytes - 1)) != '0)
      acc_err = 1'b1;
    else if (end_addr > (AW+1)'(SIZE))
      acc_err = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    accept        = 1'b0;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        bus.req_ready = !rst;
        accept        = bus.req_valid && !rst;
        if (bus.req_valid) state_d = RESP;
      end
      RESP: begin
        bus.rsp_valid = !rst;
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (accept && bus.req_we && !acc_err)
      for (int i = 0; i < NB; i++)
        if (i < nbytes) mem[bus.req_addr + AW'(i)] <= bus.req_wdata[8*i +: 8];
  end

  always_comb begin
    for (int i = 0; i < NB; i++)
      raw[i] = mem[bus.req_addr + AW'(i)];
  end

  data_ram_extend #(.N(N)) u_extend (
    .raw  (raw),
    .sz   (bus.req_size),
    .uns  (bus.req_unsigned),
    .data (ext_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      rdata_q <= (bus.req_we || acc_err) ? '0 : ext_data;
      err_q   <= acc_err;
    end
  end

  assign bus.rsp_rdata = rst ? '0 : rdata_q;
  assign bus.rsp_err   = !rst && err_q;

endmodule
